// File: rtl/bfloat16_result_fifo_if.sv
// Register-bus bundle used by the result FIFO: valid/ready request with byte strobes.
// The master drives the request and the slave returns the one-cycle ack with read data.
interface bfloat16_result_fifo_if;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport master (output valid, addr, wdata, wstrb, input ready, rdata);
    modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/bfloat16_result_fifo.sv
// Circular FIFO that captures FMA results with their exception flags for CPU readout.
// It raises a level interrupt once the fill level reaches a programmable threshold.
module bfloat16_result_fifo #(
    parameter int          DEPTH     = 8,
    parameter int          AW        = 3,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0100
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 res_valid,
    input  logic [31:0]          res_data,
    input  logic [9:0]           res_flags,
    bfloat16_result_fifo_if.slave bus,
    output logic                 irq,
    output logic [AW:0]          count
);

    typedef enum logic {S_IDLE, S_ACK} bus_state_t;

    bus_state_t    state, state_n;
    logic [41:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          ovf, udf, irq_en;
    logic [7:0]    threshold;
    logic [31:0]   rdata_q, rdata_n;
    logic [41:0]   head;
    logic [1:0]    reg_sel;
    logic          in_win, do_ack, is_read, full, empty;
    logic          do_pop, do_push, do_flush, set_ovf, set_udf, status_wr, ctrl_wr;
    logic          unused_bits;

    assign head    = mem[rd_ptr];
    assign reg_sel = bus.addr[3:2];
    assign is_read = (bus.wstrb == 4'b0000);
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);

    assign bus.ready = (state == S_ACK);
    assign bus.rdata = rdata_q;

    assign unused_bits = ^{bus.addr[1:0], bus.wdata[30:16], bus.wdata[7:6], bus.wdata[3:1]};

    // The ack cycle always falls back to idle, which guarantees a low cycle between acks.
    always_comb begin
        state_n = state;
        do_ack  = 1'b0;
        in_win  = bus.valid && (bus.addr[31:4] == BASE_ADDR[31:4]);
        case (state)
            S_IDLE: if (in_win) begin
                state_n = S_ACK;
                do_ack  = 1'b1;
            end
            S_ACK:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        do_pop    = do_ack && is_read && (reg_sel == 2'd0) && !empty;
        set_udf   = do_ack && is_read && (reg_sel == 2'd0) && empty;
        status_wr = do_ack && !is_read && (reg_sel == 2'd2) && bus.wstrb[0];
        ctrl_wr   = do_ack && !is_read && (reg_sel == 2'd3);
        do_flush  = ctrl_wr && bus.wstrb[3] && bus.wdata[31];
        // A pop on the same edge frees a slot, so a full FIFO still accepts the push.
        do_push   = res_valid && (!full || do_pop) && !do_flush;
        set_ovf   = res_valid && full && !do_pop && !do_flush;

        rdata_n = '0;
        if (is_read) begin
            case (reg_sel)
                2'd0: rdata_n = empty ? '0 : head[31:0];
                2'd1: rdata_n = {22'b0, head[41:32]};
                2'd2: rdata_n = {16'b0, threshold, ovf, udf, full, empty, 4'(count)};
                2'd3: rdata_n = {16'b0, threshold, 7'b0, irq_en};
                default: rdata_n = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= {res_flags, res_data};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            rdata_q   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            udf       <= 1'b0;
            irq_en    <= 1'b0;
            threshold <= 8'(DEPTH);
            irq       <= 1'b0;
        end else begin
            state   <= state_n;
            rdata_q <= do_ack ? rdata_n : '0;

            if (do_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
            end

            ovf <= (ovf && !(status_wr && bus.wdata[5])) || set_ovf;
            udf <= (udf && !(status_wr && bus.wdata[4])) || set_udf;

            if (ctrl_wr && bus.wstrb[0]) irq_en <= bus.wdata[0];
            if (ctrl_wr && bus.wstrb[1])
                threshold <= (bus.wdata[15:8] == 8'd0) ? 8'd1 : bus.wdata[15:8];

            irq <= irq_en && ((8'(count) >= threshold) || ovf);
        end
    end

endmodule

// File: tb/tb_bfloat16_result_fifo.sv
// Randomized and directed checks of the result FIFO against a queue-based model.
// Each scenario task drives the DUT and compares against the model inline.
module tb_bfloat16_result_fifo;
    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h3000_0100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        res_valid = 1'b0;
    logic [31:0] res_data = '0;
    logic [9:0]  res_flags = '0;
    logic        irq;
    logic [3:0]  count;

    bfloat16_result_fifo_if bus();

    bfloat16_result_fifo #(.DEPTH(DEPTH), .AW(3), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .res_valid(res_valid), .res_data(res_data),
        .res_flags(res_flags), .bus(bus.slave), .irq(irq), .count(count)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model: the FIFO contents as a queue plus the software-visible state.
    logic [41:0] q[$];
    bit          m_ovf, m_udf, m_irq_en;
    int          m_thr;

    function automatic void model_reset();
        q.delete();
        m_ovf = 0; m_udf = 0; m_irq_en = 0; m_thr = DEPTH;
    endfunction

    function automatic logic [31:0] model_status();
        int s;
        s = (m_thr << 8) + (int'(m_ovf) << 7) + (int'(m_udf) << 6)
          + (int'(q.size() == DEPTH) << 5) + (int'(q.size() == 0) << 4) + (q.size() % 16);
        return 32'(s);
    endfunction

    function automatic bit model_irq();
        return m_irq_en && ((q.size() >= m_thr) || m_ovf);
    endfunction

    function automatic void model_push(input logic [41:0] e);
        if (q.size() < DEPTH) q.push_back(e);
        else m_ovf = 1;
    endfunction

    function automatic logic [31:0] model_bus(input int r, input logic [31:0] wd,
                                              input logic [3:0] ws, input bit push,
                                              input logic [41:0] pe);
        logic [31:0] rd;
        bit flush;
        rd = 0; flush = 0;
        if (ws == 0) begin
            case (r)
                0: if (q.size() > 0) begin rd = q[0][31:0]; void'(q.pop_front()); end
                   else m_udf = 1;
                1: rd = (q.size() > 0) ? 32'(q[0][41:32]) : 32'h0;
                2: rd = model_status();
                default: rd = 32'(m_thr * 256 + int'(m_irq_en));
            endcase
        end else if (r == 2 && ws[0]) begin
            if (wd[5]) m_ovf = 0;
            if (wd[4]) m_udf = 0;
        end else if (r == 3) begin
            if (ws[0]) m_irq_en = wd[0];
            if (ws[1]) m_thr = (wd[15:8] == 0) ? 1 : int'(wd[15:8]);
            flush = ws[3] && wd[31];
        end
        if (flush) q.delete();
        if (push && !flush) model_push(pe);
        return rd;
    endfunction

    task automatic bus_op(input int r, input logic [31:0] wd, input logic [3:0] ws,
                          input bit push, input logic [41:0] pe, output logic [31:0] rd);
        bit ok;
        ok = 0; rd = '0;
        bus.valid = 1; bus.addr = BASE + 32'(r * 4); bus.wdata = wd; bus.wstrb = ws;
        if (push) begin res_valid = 1; res_data = pe[31:0]; res_flags = pe[41:32]; end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            res_valid = 0;
            if (bus.ready) begin ok = 1; rd = bus.rdata; break; end
        end
        bus.valid = 0; bus.wstrb = '0;
        @(posedge clk); #1;
        total_cnt++;
        if (!ok) $display("FAIL bus_timeout reg=%0d ready=0 required=1", r);
        else if (bus.ready !== 1'b0) $display("FAIL ack_width ready=%b required=0", bus.ready);
        else pass_cnt++;
    endtask

    task automatic push(input logic [41:0] e);
        res_valid = 1; res_data = e[31:0]; res_flags = e[41:32];
        @(posedge clk); #1;
        res_valid = 0;
        model_push(e);
    endtask

    task automatic test_reset();
        logic [31:0] rd, exp;
        reset = 1;
        bus.valid = 0; bus.addr = '0; bus.wdata = '0; bus.wstrb = '0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (count !== 4'd0 || irq !== 1'b0 || bus.ready !== 1'b0 || bus.rdata !== 32'h0)
            $display("FAIL reset_outputs count=%0d irq=%b ready=%b rdata=%h required=0", count, irq, bus.ready, bus.rdata);
        else pass_cnt++;
        reset = 0;
        model_reset();
        exp = model_bus(2, 0, 0, 0, 0);
        bus_op(2, 0, 0, 0, 0, rd);
        total_cnt++;
        if (rd !== 32'h0000_0810 || rd !== exp)
            $display("FAIL reset_status got=%h required=%h", rd, 32'h0000_0810);
        else pass_cnt++;
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL reset_irq got=%b required=0", irq);
        else pass_cnt++;
    endtask

    task automatic test_fifo_order();
        logic [31:0] rd, exp;
        logic [41:0] e [3];
        e[0] = {10'h001, 32'h3F80_0000};
        e[1] = {10'h000, 32'h4000_0000};
        e[2] = {10'h004, 32'hC040_0000};
        for (int i = 0; i < 3; i++) push(e[i]);
        total_cnt++;
        if (count !== 4'd3) $display("FAIL order_count got=%0d required=3", count);
        else pass_cnt++;
        exp = model_bus(1, 0, 0, 0, 0);
        bus_op(1, 0, 0, 0, 0, rd);
        total_cnt++;
        if (rd !== 32'h1 || rd !== exp) $display("FAIL order_flags got=%h required=%h", rd, 32'h1);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            exp = model_bus(0, 0, 0, 0, 0);
            bus_op(0, 0, 0, 0, 0, rd);
            total_cnt++;
            if (rd !== exp || rd !== e[i][31:0]) $display("FAIL order_data%0d got=%h required=%h", i, rd, e[i][31:0]);
            else pass_cnt++;
        end
        exp = model_bus(2, 0, 0, 0, 0);
        bus_op(2, 0, 0, 0, 0, rd);
        total_cnt++;
        if (count !== 4'd0 || rd !== exp || rd[4] !== 1'b1)
            $display("FAIL order_empty count=%0d status=%h required status=%h", count, rd, exp);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        logic [31:0] rd, exp;
        for (int i = 0; i < 9; i++) push({10'($urandom), 32'($urandom)});
        exp = model_bus(2, 0, 0, 0, 0);
        bus_op(2, 0, 0, 0, 0, rd);
        total_cnt++;
        if (count !== 4'd8 || rd !== exp || rd[7] !== 1'b1 || rd[5] !== 1'b1)
            $display("FAIL ovf_status count=%0d status=%h required=%h", count, rd, exp);
        else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            exp = model_bus(0, 0, 0, 0, 0);
            bus_op(0, 0, 0, 0, 0, rd);
            total_cnt++;
            if (rd !== exp) $display("FAIL ovf_drain%0d got=%h required=%h", i, rd, exp);
            else pass_cnt++;
        end
        exp = model_bus(2, 32'h20, 4'b0001, 0, 0);
        bus_op(2, 32'h20, 4'b0001, 0, 0, rd);
        exp = model_bus(2, 0, 0, 0, 0);
        bus_op(2, 0, 0, 0, 0, rd);
        total_cnt++;
        if (rd !== exp || rd[7] !== 1'b0) $display("FAIL ovf_clear status=%h required=%h", rd, exp);
        else pass_cnt++;
    endtask

    task automatic test_push_pop_full();
        logic [31:0] rd, exp;
        logic [41:0] newest;
        for (int i = 0; i < DEPTH; i++) push({10'($urandom), 32'($urandom)});
        newest = {10'h2AA, 32'hDEAD_BEEF};
        exp = model_bus(0, 0, 0, 1, newest);
        bus_op(0, 0, 0, 1, newest, rd);
        total_cnt++;
        if (rd !== exp || count !== 4'd8) $display("FAIL pp_full data=%h count=%0d required data=%h count=8", rd, count, exp);
        else pass_cnt++;
        exp = model_bus(2, 0, 0, 0, 0);
        bus_op(2, 0, 0, 0, 0, rd);
        total_cnt++;
        if (rd !== exp || rd[7] !== 1'b0) $display("FAIL pp_full_ovf status=%h required=%h", rd, exp);
        else pass_cnt++;
        for (int i = 0; i < DEPTH; i++) begin
            exp = model_bus(0, 0, 0, 0, 0);
            bus_op(0, 0, 0, 0, 0, rd);
            total_cnt++;
            if (rd !== exp) $display("FAIL pp_drain%0d got=%h required=%h", i, rd, exp);
            else pass_cnt++;
        end
        total_cnt++;
        if (rd !== newest[31:0]) $display("FAIL pp_last got=%h required=%h", rd, newest[31:0]);
        else pass_cnt++;
    endtask

    task automatic test_irq();
        logic [31:0] rd, exp;
        exp = model_bus(3, 32'h0000_0301, 4'b1111, 0, 0);
        bus_op(3, 32'h0000_0301, 4'b1111, 0, 0, rd);
        for (int i = 0; i < 3; i++) push({10'($urandom), 32'($urandom)});
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL irq_early got=%b required=0", irq);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (irq !== 1'b1 || irq !== model_irq()) $display("FAIL irq_rise got=%b required=1", irq);
        else pass_cnt++;
        exp = model_bus(0, 0, 0, 0, 0);
        bus_op(0, 0, 0, 0, 0, rd);
        total_cnt++;
        if (irq !== 1'b0 || rd !== exp) $display("FAIL irq_fall irq=%b data=%h required irq=0 data=%h", irq, rd, exp);
        else pass_cnt++;
        exp = model_bus(3, 0, 0, 0, 0);
        bus_op(3, 0, 0, 0, 0, rd);
        total_cnt++;
        if (rd !== 32'h0000_0301 || rd !== exp) $display("FAIL ctrl_read got=%h required=%h", rd, 32'h301);
        else pass_cnt++;
        exp = model_bus(3, 32'h0, 4'b0010, 0, 0);
        bus_op(3, 32'h0, 4'b0010, 0, 0, rd);
        exp = model_bus(3, 0, 0, 0, 0);
        bus_op(3, 0, 0, 0, 0, rd);
        total_cnt++;
        if (rd !== 32'h0000_0101 || rd !== exp) $display("FAIL thr_zero got=%h required=%h", rd, 32'h101);
        else pass_cnt++;
        exp = model_bus(3, 32'h0000_0800, 4'b0011, 0, 0);
        bus_op(3, 32'h0000_0800, 4'b0011, 0, 0, rd);
        while (q.size() > 0) begin
            exp = model_bus(0, 0, 0, 0, 0);
            bus_op(0, 0, 0, 0, 0, rd);
        end
    endtask

    task automatic test_out_of_window();
        bit seen;
        seen = 0;
        push({10'h011, 32'h1111_1111});
        push({10'h022, 32'h2222_2222});
        bus.valid = 1; bus.addr = BASE + 32'h10; bus.wstrb = 4'b0000; bus.wdata = '0;
        repeat (4) begin @(posedge clk); #1; if (bus.ready) seen = 1; end
        bus.valid = 0;
        @(posedge clk); #1;
        total_cnt++;
        if (seen || count !== 4'd2) $display("FAIL out_of_window ready_seen=%b count=%0d required 0/2", seen, count);
        else pass_cnt++;
    endtask

    task automatic test_flush_udf_reset();
        logic [31:0] rd, exp;
        logic [41:0] e;
        while (q.size() < 5) push({10'($urandom), 32'($urandom)});
        e = {10'h3FF, 32'h1234_5678};
        exp = model_bus(3, 32'h8000_0000, 4'b1000, 1, e);
        bus_op(3, 32'h8000_0000, 4'b1000, 1, e, rd);
        total_cnt++;
        if (count !== 4'd0) $display("FAIL flush_count got=%0d required=0", count);
        else pass_cnt++;
        exp = model_bus(0, 0, 0, 0, 0);
        bus_op(0, 0, 0, 0, 0, rd);
        total_cnt++;
        if (rd !== 32'h0 || rd !== exp) $display("FAIL udf_data got=%h required=0", rd);
        else pass_cnt++;
        exp = model_bus(2, 0, 0, 0, 0);
        bus_op(2, 0, 0, 0, 0, rd);
        total_cnt++;
        if (rd !== exp || rd[6] !== 1'b1) $display("FAIL udf_status got=%h required=%h", rd, exp);
        else pass_cnt++;
        push({10'($urandom), 32'($urandom)});
        push({10'($urandom), 32'($urandom)});
        bus.valid = 1; bus.addr = BASE + 32'h8; bus.wstrb = '0;
        for (int i = 0; i < 8 && bus.ready !== 1'b1; i++) begin @(posedge clk); #1; end
        total_cnt++;
        if (bus.ready !== 1'b1) $display("FAIL midack_wait ready=0 required=1");
        else pass_cnt++;
        #2 reset = 1;
        #1;
        total_cnt++;
        if (bus.ready !== 1'b0 || count !== 4'd0) $display("FAIL midack_reset ready=%b count=%0d required 0/0", bus.ready, count);
        else pass_cnt++;
        bus.valid = 0;
        @(posedge clk); #1;
        reset = 0;
        model_reset();
    endtask

    task automatic test_random();
        logic [31:0] rd, exp, wd;
        logic [3:0]  ws;
        logic [41:0] e;
        int op, r;
        bit pu;
        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 9);
            e  = {10'($urandom), 32'($urandom)};
            if (op <= 3) push(e);
            else begin
                pu = 0; wd = '0; ws = '0;
                if (op <= 5) begin r = 0; pu = $urandom_range(0, 1) == 1; end
                else if (op == 6) r = (q.size() > 0) ? 1 : 3;
                else if (op == 7) r = 2;
                else if (op == 8) begin
                    r  = 3;
                    wd = {($urandom_range(0, 15) == 0), 15'b0, 8'($urandom_range(0, 9)), 7'b0, 1'($urandom)};
                    ws = 4'($urandom_range(1, 15));
                    pu = $urandom_range(0, 3) == 0;
                end else begin
                    r = 2; wd = $urandom; ws = 4'($urandom_range(1, 15));
                end
                exp = model_bus(r, wd, ws, pu, e);
                bus_op(r, wd, ws, pu, e, rd);
                if (ws == 0) begin
                    total_cnt++;
                    if (rd !== exp) $display("FAIL rand_read%0d reg=%0d got=%h required=%h", n, r, rd, exp);
                    else pass_cnt++;
                end
            end
            total_cnt++;
            if (count !== 4'(q.size())) $display("FAIL rand_count%0d got=%0d required=%0d", n, count, q.size());
            else pass_cnt++;
            @(posedge clk); #1;
            total_cnt++;
            if (irq !== model_irq()) $display("FAIL rand_irq%0d got=%b required=%b", n, irq, model_irq());
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_fifo_order();
        test_overflow();
        test_push_pop_full();
        test_irq();
        test_out_of_window();
        test_flush_udf_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
